// File: rtl/dmem_check_harness.sv
// rtl/dmem_check_harness.sv - CPU run sequencer and data-memory checker against an expected image
// Optional build macro MISMATCH_STOP_EN: abort the scan at the first mismatching word.
module dmem_check_harness #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 16,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              exp_we,
    input  logic [AW-1:0]     exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              dut_rst,
    output logic [AW-1:0]     dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CW-1:0]     mismatch_cnt,
    output logic [AW-1:0]     first_fail
);

    // One shared phase counter covers the reset hold, the run window and the scan.
    localparam int CNT_A   = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int CNT_MAX = (CNT_A > DEPTH) ? CNT_A : DEPTH;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] RST_LAST  = CNTW'(RST_CYCLES - 1);
    localparam logic [CNTW-1:0] RUN_LAST  = CNTW'(RUN_CYCLES - 1);
    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] ADDR_LAST = CNTW'(DEPTH - 1);
    localparam logic [AW:0]     DEPTH_V   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNTW-1:0]   cnt;
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [AW-1:0]     cmp_addr;
    logic              cmp_en;
    logic              mismatch;
    logic              idle_or_done;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);

    // Word read at scan step k arrives at step k+1, so compare against cnt-1.
    assign cmp_addr = AW'(cnt - 1'b1);
    assign cmp_en   = (state_q == S_SCAN) && (cnt != '0);
    assign mismatch = cmp_en && (dbg_data != exp_mem[cmp_addr]);

    assign dut_rst = !((state_q == S_IDLE) || (state_q == S_RESET));
    assign busy    = (state_q == S_RESET) || (state_q == S_RUN) || (state_q == S_SCAN);
    assign done    = (state_q == S_DONE);
    assign pass    = (state_q == S_DONE) && (mismatch_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RESET;
            end
            S_RESET: begin
                if (cnt == RST_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt == RUN_LAST) state_d = S_SCAN;
            end
            S_SCAN: begin
`ifdef MISMATCH_STOP_EN
                if (mismatch || (cnt == SCAN_LAST)) state_d = S_DONE;
`else
                if (cnt == SCAN_LAST) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                if (start) state_d = S_RESET;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dbg_addr     <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else begin
            if ((state_d != state_q) || idle_or_done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if ((state_q == S_RUN) && (state_d == S_SCAN)) begin
                dbg_addr <= '0;
            end else if ((state_q == S_SCAN) && (cnt < ADDR_LAST)) begin
                dbg_addr <= AW'(cnt + 1'b1);
            end

            if (idle_or_done && start) begin
                mismatch_cnt <= '0;
                first_fail   <= '0;
            end else if (mismatch) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (mismatch_cnt == '0) first_fail <= cmp_addr;
            end
        end
    end

    // Expected image survives reset; it is only writable while no run is in flight.
    always_ff @(posedge clk) begin
        if (exp_we && idle_or_done && ({1'b0, exp_addr} < DEPTH_V)) begin
            exp_mem[exp_addr] <= exp_data;
        end
    end

endmodule
